// File: rtl/data_relevant_sb.sv
// data_relevant_sb: ID-stage operand forwarding plus per-register latency scoreboard.
// Optional feature: define DR_STALL_CNT_EN to implement the stall_cycles counter.

module data_relevant_sb_port #(
  parameter int FWD_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int DATA_W     = 32
) (
  input  logic                                rd_en,
  input  logic [REG_AW-1:0]                   raddr,
  input  logic [DATA_W-1:0]                   rdata,
  input  logic [FWD_STAGES-1:0]               fwd_we,
  input  logic [FWD_STAGES-1:0][REG_AW-1:0]   fwd_waddr,
  input  logic [FWD_STAGES-1:0][DATA_W-1:0]   fwd_wdata,
  input  logic [FWD_STAGES-1:0]               fwd_data_ok,
  input  logic [(2**REG_AW)-1:0]              busy,
  output logic [DATA_W-1:0]                   data,
  output logic                                hazard
);
  logic [DATA_W-1:0] sel_data;
  logic              sel_ok;
  logic              nz;

  // Walk oldest to youngest so the youngest matching stage overwrites last.
  always_comb begin
    sel_data = rdata;
    sel_ok   = 1'b1;
    for (int s = FWD_STAGES - 1; s >= 0; s--) begin
      if (fwd_we[s] && (fwd_waddr[s] == raddr)) begin
        sel_data = fwd_wdata[s];
        sel_ok   = fwd_data_ok[s];
      end
    end
    nz     = (raddr != '0);
    data   = nz ? sel_data : '0;
    hazard = rd_en && nz && (busy[raddr] || !sel_ok);
  end
endmodule

module data_relevant_sb #(
  parameter int RD_PORTS   = 2,
  parameter int FWD_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int DATA_W     = 32,
  parameter int LAT_W      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic [RD_PORTS-1:0]            id_rd_en,
  input  logic [RD_PORTS*REG_AW-1:0]     id_raddr,
  input  logic [RD_PORTS*DATA_W-1:0]     id_rdata,
  input  logic                           id_wen,
  input  logic [REG_AW-1:0]              id_waddr,
  input  logic [LAT_W-1:0]               id_lat,
  input  logic                           id_fire,
  input  logic [FWD_STAGES-1:0]          fwd_we,
  input  logic [FWD_STAGES*REG_AW-1:0]   fwd_waddr,
  input  logic [FWD_STAGES*DATA_W-1:0]   fwd_wdata,
  input  logic [FWD_STAGES-1:0]          fwd_data_ok,
  input  logic                           wb_we,
  input  logic [REG_AW-1:0]              wb_waddr,
  input  logic                           flush,
  output logic [RD_PORTS*DATA_W-1:0]     fwd_rdata,
  output logic                           id_ready,
  output logic [15:0]                    stall_cycles
);
  localparam int NREG = 1 << REG_AW;

  logic [RD_PORTS-1:0][REG_AW-1:0]   raddr_v;
  logic [RD_PORTS-1:0][DATA_W-1:0]   rdata_v;
  logic [RD_PORTS-1:0][DATA_W-1:0]   res_v;
  logic [RD_PORTS-1:0]               hazard_v;
  logic [FWD_STAGES-1:0][REG_AW-1:0] fwd_waddr_v;
  logic [FWD_STAGES-1:0][DATA_W-1:0] fwd_wdata_v;

  logic [NREG-1:0]             pending;
  logic [NREG-1:0][LAT_W-1:0]  cnt;
  logic [NREG-1:0]             busy;
  logic                        alloc;

  assign raddr_v     = id_raddr;
  assign rdata_v     = id_rdata;
  assign fwd_waddr_v = fwd_waddr;
  assign fwd_wdata_v = fwd_wdata;
  assign fwd_rdata   = res_v;

  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG; r++) busy[r] = pending[r] && (cnt[r] != '0);
  end

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_port
    data_relevant_sb_port #(
      .FWD_STAGES(FWD_STAGES), .REG_AW(REG_AW), .DATA_W(DATA_W)
    ) u_port (
      .rd_en       (id_rd_en[i]),
      .raddr       (raddr_v[i]),
      .rdata       (rdata_v[i]),
      .fwd_we      (fwd_we),
      .fwd_waddr   (fwd_waddr_v),
      .fwd_wdata   (fwd_wdata_v),
      .fwd_data_ok (fwd_data_ok),
      .busy        (busy),
      .data        (res_v[i]),
      .hazard      (hazard_v[i])
    );
  end

  assign id_ready = ~(id_valid && (|hazard_v));
  // A fire that arrives while stalled is a protocol error and must not allocate.
  assign alloc    = id_fire && id_ready && id_wen && (id_waddr != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pending <= '0;
      cnt     <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (alloc && (id_waddr == REG_AW'(r))) begin
          pending[r] <= 1'b1;
          cnt[r]     <= id_lat;
        end else begin
          if (cnt[r] != '0) cnt[r] <= cnt[r] - LAT_W'(1);
          if (wb_we && (wb_waddr == REG_AW'(r))) pending[r] <= 1'b0;
        end
      end
    end
  end

`ifdef DR_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (id_valid && !id_ready && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'h0;
`endif
endmodule

// File: tb/tb_data_relevant_sb.sv
// Directed bench for data_relevant_sb: a cycle-level scoreboard model checked every
// cycle, plus literal expectations that pin the model at key points.

module tb_data_relevant_sb;
  localparam int NREG = 32;

  logic        clk, rst;
  logic        id_valid;
  logic [1:0]  id_rd_en;
  logic [9:0]  id_raddr;
  logic [63:0] id_rdata;
  logic        id_wen;
  logic [4:0]  id_waddr;
  logic [3:0]  id_lat;
  logic        id_fire;
  logic [2:0]  fwd_we;
  logic [14:0] fwd_waddr;
  logic [95:0] fwd_wdata;
  logic [2:0]  fwd_data_ok;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic        flush;
  logic [63:0] fwd_rdata;
  logic        id_ready;
  logic [15:0] stall_cycles;

  data_relevant_sb dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd_en(id_rd_en),
    .id_raddr(id_raddr), .id_rdata(id_rdata), .id_wen(id_wen),
    .id_waddr(id_waddr), .id_lat(id_lat), .id_fire(id_fire),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .fwd_data_ok(fwd_data_ok), .wb_we(wb_we), .wb_waddr(wb_waddr),
    .flush(flush), .fwd_rdata(fwd_rdata), .id_ready(id_ready),
    .stall_cycles(stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_pass = 0;
  bit started = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Model: a register is busy while it is pending and the current cycle is before
  // the cycle its producer result becomes forwardable.
  int cyc = 0;
  bit m_pend[NREG];
  int m_rdy_cyc[NREG];
  int m_stall = 0;

  function automatic logic [4:0] m_raddr(int i);
    logic [9:0] a;
    a = id_raddr;
    return a[i*5 +: 5];
  endfunction

  function automatic logic [31:0] m_data(int i);
    logic [4:0] a;
    a = m_raddr(i);
    if (a == 0) return 32'h0;
    for (int s = 0; s < 3; s++)
      if (fwd_we[s] && fwd_waddr[s*5 +: 5] == a) return fwd_wdata[s*32 +: 32];
    return id_rdata[i*32 +: 32];
  endfunction

  function automatic bit m_haz(int i);
    logic [4:0] a;
    a = m_raddr(i);
    if (!id_rd_en[i] || a == 0) return 1'b0;
    if (m_pend[a] && cyc < m_rdy_cyc[a]) return 1'b1;
    for (int s = 0; s < 3; s++)
      if (fwd_we[s] && fwd_waddr[s*5 +: 5] == a) return !fwd_data_ok[s];
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    return !(id_valid && (m_haz(0) || m_haz(1)));
  endfunction

  function automatic int m_stall_exp();
`ifdef DR_STALL_CNT_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) begin
    bit alloc;
    alloc = id_fire && m_ready() && id_wen && id_waddr != 0;
    if (rst) begin
      for (int r = 0; r < NREG; r++) m_pend[r] = 0;
      m_stall = 0;
    end else begin
      if (id_valid && !m_ready() && m_stall < 65535) m_stall++;
      if (flush) begin
        for (int r = 0; r < NREG; r++) m_pend[r] = 0;
      end else begin
        if (wb_we && !(alloc && id_waddr == wb_waddr)) m_pend[wb_waddr] = 0;
        if (alloc) begin
          m_pend[id_waddr]    = 1;
          m_rdy_cyc[id_waddr] = cyc + 1 + int'(id_lat);
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      chk("mdl_p0", fwd_rdata[31:0], m_data(0));
      chk("mdl_p1", fwd_rdata[63:32], m_data(1));
      chk("mdl_ready", {31'b0, id_ready}, {31'b0, m_ready()});
      chk("mdl_stall", {16'b0, stall_cycles}, m_stall_exp());
      if (id_fire) chk("fire_proto", {31'b0, id_ready}, 32'd1);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rd_en = 0; id_wen = 0; id_waddr = 0; id_lat = 0; id_fire = 0;
    fwd_we = 0; fwd_waddr = 0; fwd_wdata = 0; fwd_data_ok = 3'b111;
    wb_we = 0; wb_waddr = 0; flush = 0;
    id_rdata = {32'h2222_2222, 32'h1111_1111};
  endtask

`ifdef DR_STALL_CNT_EN
  localparam logic [31:0] STALL3 = 32'd3;
`else
  localparam logic [31:0] STALL3 = 32'd0;
`endif

  initial begin
    idle();
    id_raddr = {5'd0, 5'd3};
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    started = 1;

    // Reset state
    @(negedge clk);
    chk("rst_ready", {31'b0, id_ready}, 32'd1);
    chk("rst_p0", fwd_rdata[31:0], 32'h1111_1111);
    chk("rst_p1_x0", fwd_rdata[63:32], 32'h0);
    chk("rst_stall", {16'b0, stall_cycles}, 32'd0);
    nxt();

    // Multi-cycle producer on x9, latency 3
    id_valid = 1; id_fire = 1; id_wen = 1; id_waddr = 9; id_lat = 3;
    @(negedge clk); chk("mc_issue", {31'b0, id_ready}, 32'd1);
    nxt();
    id_fire = 0; id_wen = 0; id_rd_en = 2'b01; id_raddr = {5'd0, 5'd9};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("mc_stall", {31'b0, id_ready}, 32'd0);
      nxt();
    end
    @(negedge clk);
    chk("mc_ready4", {31'b0, id_ready}, 32'd1);
    chk("mc_stall_cnt", {16'b0, stall_cycles}, STALL3);
    nxt();

    // Forwarding priority
    idle(); id_valid = 1; id_rd_en = 2'b11; id_raddr = {5'd6, 5'd5};
    fwd_we = 3'b111; fwd_waddr = {5'd5, 5'd5, 5'd5};
    fwd_wdata = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    @(negedge clk);
    chk("fw_p0_A", fwd_rdata[31:0], 32'hAAAA_0000);
    chk("fw_p1_raw", fwd_rdata[63:32], 32'h2222_2222);
    chk("fw_ready", {31'b0, id_ready}, 32'd1);
    nxt(); fwd_we = 3'b110;
    @(negedge clk); chk("fw_p0_B", fwd_rdata[31:0], 32'hBBBB_0001);
    nxt(); fwd_we = 3'b100;
    @(negedge clk); chk("fw_p0_C", fwd_rdata[31:0], 32'hCCCC_0002);
    nxt(); fwd_we = 3'b111; fwd_waddr = {5'd5, 5'd6, 5'd5};
    @(negedge clk);
    chk("fw_mix_p0", fwd_rdata[31:0], 32'hAAAA_0000);
    chk("fw_mix_p1", fwd_rdata[63:32], 32'hBBBB_0001);
    nxt();

    // Load-use on x7
    idle(); id_valid = 1; id_rd_en = 2'b01; id_raddr = {5'd0, 5'd7};
    fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd7};
    fwd_wdata = {32'h0, 32'h0, 32'h7777_0007}; fwd_data_ok = 3'b110;
    @(negedge clk); chk("lu_stall", {31'b0, id_ready}, 32'd0);
    nxt(); fwd_data_ok = 3'b111;
    @(negedge clk);
    chk("lu_ready", {31'b0, id_ready}, 32'd1);
    chk("lu_data", fwd_rdata[31:0], 32'h7777_0007);
    nxt(); fwd_we = 3'b011; fwd_waddr = {5'd0, 5'd7, 5'd7}; fwd_data_ok = 3'b101;
    @(negedge clk); chk("lu_young_ok", {31'b0, id_ready}, 32'd1);
    nxt(); fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd7}; fwd_data_ok = 3'b110;
    id_rd_en = 2'b10;
    @(negedge clk); chk("lu_unused", {31'b0, id_ready}, 32'd1);
    nxt(); id_rd_en = 2'b01; id_valid = 0;
    @(negedge clk); chk("lu_novalid", {31'b0, id_ready}, 32'd1);
    nxt();

    // Zero register
    idle(); id_valid = 1; id_rd_en = 2'b01; id_raddr = {5'd0, 5'd0};
    fwd_we = 3'b001; fwd_waddr = 15'd0; fwd_wdata = {64'h0, 32'hDEAD_BEEF};
    fwd_data_ok = 3'b110;
    @(negedge clk);
    chk("x0_data", fwd_rdata[31:0], 32'h0);
    chk("x0_ready", {31'b0, id_ready}, 32'd1);
    id_fire = 1; id_wen = 1; id_waddr = 0; id_lat = 5;
    nxt(); id_fire = 0; id_wen = 0; fwd_we = 0;
    @(negedge clk); chk("x0_nopend", {31'b0, id_ready}, 32'd1);
    nxt();

    // Allocate and retire x4 in the same cycle: allocation wins
    idle(); id_valid = 1; id_fire = 1; id_wen = 1; id_waddr = 4; id_lat = 2;
    wb_we = 1; wb_waddr = 4;
    nxt(); id_fire = 0; id_wen = 0; wb_we = 0; id_rd_en = 2'b10; id_raddr = {5'd4, 5'd0};
    @(negedge clk); chk("ac_stall1", {31'b0, id_ready}, 32'd0);
    nxt();
    @(negedge clk); chk("ac_stall2", {31'b0, id_ready}, 32'd0);
    nxt();
    @(negedge clk); chk("ac_ready", {31'b0, id_ready}, 32'd1);
    nxt();

    // Retirement clears a pending x10 early
    idle(); id_valid = 1; id_fire = 1; id_wen = 1; id_waddr = 10; id_lat = 5;
    nxt(); id_fire = 0; id_wen = 0; id_rd_en = 2'b01; id_raddr = {5'd0, 5'd10};
    wb_we = 1; wb_waddr = 10;
    @(negedge clk); chk("wb_stall", {31'b0, id_ready}, 32'd0);
    nxt(); wb_we = 0;
    @(negedge clk); chk("wb_cleared", {31'b0, id_ready}, 32'd1);
    nxt();

    // Flush clears x3
    idle(); id_valid = 1; id_fire = 1; id_wen = 1; id_waddr = 3; id_lat = 7;
    nxt(); id_fire = 0; id_wen = 0; id_rd_en = 2'b01; id_raddr = {5'd0, 5'd3}; flush = 1;
    @(negedge clk); chk("fl_stall", {31'b0, id_ready}, 32'd0);
    nxt(); flush = 0;
    @(negedge clk); chk("fl_ready", {31'b0, id_ready}, 32'd1);
    nxt();

    // Reset mid-count on x11
    idle(); id_valid = 1; id_fire = 1; id_wen = 1; id_waddr = 11; id_lat = 9;
    nxt(); id_fire = 0; id_wen = 0; id_rd_en = 2'b01; id_raddr = {5'd0, 5'd11};
    @(negedge clk); chk("rs_stall", {31'b0, id_ready}, 32'd0);
    nxt(); rst = 1;
    nxt(); rst = 0;
    @(negedge clk);
    chk("rs_ready", {31'b0, id_ready}, 32'd1);
    chk("rs_stall_cnt", {16'b0, stall_cycles}, 32'd0);
    nxt();
    idle();
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
